// File: rtl/timebase_pkg.sv
// Shared definitions for the digital-clock timebase: mode encodings,
// default divisors and a counter-width helper.
package timebase_pkg;

   typedef enum logic [1:0] {
      MODE_IDLE  = 2'b00,
      MODE_RUN   = 2'b01,
      MODE_PAUSE = 2'b10,
      MODE_SET   = 2'b11
   } mode_e;

   localparam int unsigned BASE_DIV_DEF    = 500000;
   localparam int unsigned SCAN_DIV_DEF    = 62500;
   localparam int unsigned BLINK_TICKS_DEF = 25;
   localparam int unsigned REP_DELAY_DEF   = 50;
   localparam int unsigned REP_PERIOD_DEF  = 10;
   localparam int unsigned HUND_MOD        = 100;

   // A modulus of 1 still needs a one-bit register.
   function automatic int unsigned cnt_width(input int unsigned modulus);
      return (modulus > 1) ? $clog2(modulus) : 1;
   endfunction

   // set_req outranks pause_req, which outranks run_req.
   function automatic mode_e next_mode(input mode_e cur, input logic run_req,
                                       input logic pause_req, input logic set_req);
      next_mode = cur;
      unique case (cur)
         MODE_IDLE:  if (set_req) next_mode = MODE_SET;
                     else if (run_req) next_mode = MODE_RUN;
         MODE_RUN:   if (set_req) next_mode = MODE_SET;
                     else if (pause_req) next_mode = MODE_PAUSE;
         MODE_PAUSE: if (set_req) next_mode = MODE_SET;
                     else if (run_req) next_mode = MODE_RUN;
         MODE_SET:   if (set_req || run_req) next_mode = MODE_RUN;
         default:    next_mode = MODE_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running modulo-N prescaler; pulse is high for the one cycle
// following the cycle in which the count sits at N-1.
module tick_gen
   import timebase_pkg::*;
#(
   parameter int unsigned N = 10
) (
   input  logic clk,
   input  logic rst,
   output logic pulse
);

   localparam int unsigned W = cnt_width(N);
   localparam logic [W-1:0] LAST = W'(N - 1);

   logic [W-1:0] cnt_q, cnt_d;
   logic         pulse_q, pulse_d;

   always_comb begin
      cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
      pulse_d = (cnt_q == LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
      end
   end

   assign pulse = pulse_q;

endmodule

// File: rtl/timebase_ctrl.sv
// Timebase controller: prescaled enables, run/pause/set mode sequencing,
// hundredths count, blink level and adjust pulses with auto-repeat.
module timebase_ctrl
   import timebase_pkg::*;
#(
   parameter int unsigned BASE_DIV    = BASE_DIV_DEF,
   parameter int unsigned SCAN_DIV    = SCAN_DIV_DEF,
   parameter int unsigned BLINK_TICKS = BLINK_TICKS_DEF,
   parameter int unsigned REP_DELAY   = REP_DELAY_DEF,
   parameter int unsigned REP_PERIOD  = REP_PERIOD_DEF
) (
   input  logic       clk_50M,
   input  logic       cr,
   input  logic       run_req,
   input  logic       pause_req,
   input  logic       set_req,
   input  logic       adj_req,
   input  logic       adj_hold,
   output logic       tick_100hz,
   output logic       scan_en,
   output logic       sec_en,
   output logic       adj_pulse,
   output logic       blink,
   output logic [6:0] hund,
   output logic [1:0] mode
);

   localparam int unsigned BW = cnt_width(BLINK_TICKS);
   localparam int unsigned DW = cnt_width(REP_DELAY);
   localparam int unsigned PW = cnt_width(REP_PERIOD);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
   localparam logic [DW-1:0] DLY_LAST   = DW'(REP_DELAY - 1);
   localparam logic [PW-1:0] PER_LAST   = PW'(REP_PERIOD - 1);
   localparam logic [6:0]    HUND_LAST  = 7'(HUND_MOD - 1);

   mode_e         mode_q, mode_d;
   logic [6:0]    hund_q, hund_d;
   logic          sec_en_q, sec_en_d;
   logic          blink_q, blink_d;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic          rep_act_q, rep_act_d;
   logic [DW-1:0] rep_dly_q, rep_dly_d;
   logic [PW-1:0] rep_per_q, rep_per_d;
   logic          adj_pulse_q, adj_pulse_d;
   logic          rep_fire;
   logic          set_entry;

   tick_gen #(.N(BASE_DIV)) u_base_tick (.clk(clk_50M), .rst(cr), .pulse(tick_100hz));
   tick_gen #(.N(SCAN_DIV)) u_scan_tick (.clk(clk_50M), .rst(cr), .pulse(scan_en));

   always_comb begin
      mode_d    = next_mode(mode_q, run_req, pause_req, set_req);
      set_entry = (mode_d == MODE_SET) && (mode_q != MODE_SET);

      // The tick is judged on the current mode, so a tick that coincides
      // with a RUN-exit request is still counted.
      hund_d   = hund_q;
      sec_en_d = (mode_q == MODE_RUN) && tick_100hz && (hund_q == HUND_LAST);
      if (mode_d == MODE_SET)
         hund_d = '0;
      else if ((mode_q == MODE_RUN) && tick_100hz)
         hund_d = (hund_q == HUND_LAST) ? '0 : hund_q + 7'd1;

      blink_d = blink_q;
      bcnt_d  = bcnt_q;
      if (set_entry) begin
         blink_d = 1'b1;
         bcnt_d  = '0;
      end else if (tick_100hz) begin
         if (bcnt_q == BLINK_LAST) begin
            bcnt_d  = '0;
            blink_d = ~blink_q;
         end else begin
            bcnt_d = bcnt_q + BW'(1);
         end
      end

      // Delay phase counts to REP_DELAY, then the period phase takes over.
      rep_fire  = 1'b0;
      rep_act_d = rep_act_q;
      rep_dly_d = rep_dly_q;
      rep_per_d = rep_per_q;
      if (!adj_hold || (mode_q != MODE_SET)) begin
         rep_act_d = 1'b0;
         rep_dly_d = '0;
         rep_per_d = '0;
      end else if (tick_100hz) begin
         if (!rep_act_q) begin
            if (rep_dly_q == DLY_LAST) begin
               rep_fire  = 1'b1;
               rep_act_d = 1'b1;
               rep_dly_d = '0;
            end else begin
               rep_dly_d = rep_dly_q + DW'(1);
            end
         end else if (rep_per_q == PER_LAST) begin
            rep_fire  = 1'b1;
            rep_per_d = '0;
         end else begin
            rep_per_d = rep_per_q + PW'(1);
         end
      end
      adj_pulse_d = (mode_q == MODE_SET) && (adj_req || rep_fire);
   end

   always_ff @(posedge clk_50M) begin
      if (cr) begin
         mode_q      <= MODE_IDLE;
         hund_q      <= '0;
         sec_en_q    <= 1'b0;
         blink_q     <= 1'b0;
         bcnt_q      <= '0;
         rep_act_q   <= 1'b0;
         rep_dly_q   <= '0;
         rep_per_q   <= '0;
         adj_pulse_q <= 1'b0;
      end else begin
         mode_q      <= mode_d;
         hund_q      <= hund_d;
         sec_en_q    <= sec_en_d;
         blink_q     <= blink_d;
         bcnt_q      <= bcnt_d;
         rep_act_q   <= rep_act_d;
         rep_dly_q   <= rep_dly_d;
         rep_per_q   <= rep_per_d;
         adj_pulse_q <= adj_pulse_d;
      end
   end

   assign sec_en    = sec_en_q;
   assign adj_pulse = adj_pulse_q;
   assign blink     = blink_q;
   assign hund      = hund_q;
   assign mode      = mode_q;

endmodule

// File: tb/tb_timebase_ctrl.sv
// Bench for timebase_ctrl: a cycle model pushes the expected outputs of the
// next cycle as each input set is driven; they are popped and compared one cycle later.
module tb_timebase_ctrl;

   localparam int unsigned BASE = 10;
   localparam int unsigned SCAN = 4;
   localparam int unsigned BLNK = 3;
   localparam int unsigned RDLY = 5;
   localparam int unsigned RPER = 2;

   logic       clk_50M = 1'b0;
   logic       cr, run_req, pause_req, set_req, adj_req, adj_hold;
   logic       tick_100hz, scan_en, sec_en, adj_pulse, blink;
   logic [6:0] hund;
   logic [1:0] mode;

   timebase_ctrl #(
      .BASE_DIV(BASE), .SCAN_DIV(SCAN), .BLINK_TICKS(BLNK),
      .REP_DELAY(RDLY), .REP_PERIOD(RPER)
   ) dut (
      .clk_50M(clk_50M), .cr(cr), .run_req(run_req), .pause_req(pause_req),
      .set_req(set_req), .adj_req(adj_req), .adj_hold(adj_hold),
      .tick_100hz(tick_100hz), .scan_en(scan_en), .sec_en(sec_en),
      .adj_pulse(adj_pulse), .blink(blink), .hund(hund), .mode(mode)
   );

   always #5 clk_50M = ~clk_50M;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Scoreboard of packed {tick, scan, sec, adj, blink, hund, mode}.
   logic [13:0] exp_q[$];

   // Reference model state; mode uses 0 IDLE, 1 RUN, 2 PAUSE, 3 SET.
   int unsigned m_c, m_mode, m_hund, m_bt, m_hold;
   logic        m_blink;
   logic        hold_lvl = 1'b0;
   int unsigned n_tick, n_scan, n_sec, n_adj;

   task automatic cyc(input logic r, input logic p, input logic s,
                      input logic a, input logic h, input logic c);
      logic        tk, sec, adjp, tk_n, sc_n, fire;
      int unsigned nm;
      logic [13:0] got;
      cr = c; run_req = r; pause_req = p; set_req = s; adj_req = a; adj_hold = h;
      sec = 1'b0; adjp = 1'b0; tk_n = 1'b0; sc_n = 1'b0;
      if (c) begin
         m_c = 0; m_mode = 0; m_hund = 0; m_bt = 0; m_hold = 0; m_blink = 1'b0;
      end else begin
         tk = (m_c != 0) && (m_c % BASE == 0);
         nm = m_mode;
         if (s)                      nm = (m_mode == 3) ? 1 : 3;
         else if (p && m_mode == 1)  nm = 2;
         else if (r && m_mode != 1)  nm = 1;
         if (m_mode == 1 && tk) begin
            sec    = (m_hund == 99);
            m_hund = (m_hund + 1) % 100;
         end
         if (nm == 3) m_hund = 0;
         if (nm == 3 && m_mode != 3) begin
            m_blink = 1'b1;
            m_bt    = 0;
         end else if (tk) begin
            m_bt++;
            if (m_bt == BLNK) begin
               m_bt    = 0;
               m_blink = ~m_blink;
            end
         end
         fire = 1'b0;
         if (h && m_mode == 3) begin
            if (tk) begin
               m_hold++;
               fire = (m_hold >= RDLY) && ((m_hold - RDLY) % RPER == 0);
            end
         end else begin
            m_hold = 0;
         end
         adjp   = (m_mode == 3) && (a || fire);
         m_mode = nm;
         m_c++;
         tk_n = (m_c % BASE == 0);
         sc_n = (m_c % SCAN == 0);
      end
      exp_q.push_back({tk_n, sc_n, sec, adjp, m_blink, 7'(m_hund), 2'(m_mode)});
      @(negedge clk_50M);
      got = {tick_100hz, scan_en, sec_en, adj_pulse, blink, hund, mode};
      check_eq("outs", 32'(got), 32'(exp_q.pop_front()));
      if (tick_100hz === 1'b1) n_tick++;
      if (scan_en === 1'b1)    n_scan++;
      if (adj_pulse === 1'b1)  n_adj++;
      if (sec_en === 1'b1) begin
         n_sec++;
         check_eq("sec_wrap", 32'(hund), 32'd0);
      end
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 1'b0, 1'b0, hold_lvl, 1'b0);
   endtask

   task automatic wait_ticks(input int unsigned n);
      int unsigned seen   = 0;
      int unsigned budget = (n + 1) * BASE + 2;
      while (seen < n && budget > 0) begin
         idle();
         if (tick_100hz === 1'b1) seen++;
         budget--;
      end
      if (seen < n) check_eq("wait_ticks_timeout", 32'(seen), 32'(n));
   endtask

   task automatic wait_hund(input int unsigned v);
      int unsigned budget = 1200;
      while (hund !== 7'(v) && budget > 0) begin
         idle();
         budget--;
      end
      check_eq("wait_hund", 32'(hund), 32'(v));
   endtask

   initial begin
      cr = 1'b1; run_req = 1'b0; pause_req = 1'b0; set_req = 1'b0;
      adj_req = 1'b0; adj_hold = 1'b0;
      @(negedge clk_50M);
      repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_eq("reset_mode", 32'(mode), 32'd0);

      // Idle after reset: ticks at cycles 10/20/30, scans every 4 cycles.
      n_tick = 0; n_scan = 0; n_sec = 0; n_adj = 0;
      repeat (35) idle();
      check_eq("idle_ticks", n_tick, 32'd3);
      check_eq("idle_scans", n_scan, 32'd8);
      check_eq("idle_sec", n_sec, 32'd0);
      check_eq("idle_hund", 32'(hund), 32'd0);

      // Full hundredths cycle in RUN.
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("run_mode", 32'(mode), 32'd1);
      wait_ticks(100);
      idle();
      check_eq("run_wrap_hund", 32'(hund), 32'd0);
      check_eq("run_sec_count", n_sec, 32'd1);

      // Pause at 42 and resume without phase loss.
      wait_hund(42);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("pause_mode", 32'(mode), 32'd2);
      wait_ticks(20);
      check_eq("pause_hold", 32'(hund), 32'd42);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      wait_ticks(1);
      idle();
      check_eq("resume_hund", 32'(hund), 32'd43);

      // Coincident strobes: set wins.
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("set_mode", 32'(mode), 32'd3);
      check_eq("set_hund", 32'(hund), 32'd0);
      check_eq("set_blink", 32'(blink), 32'd1);
      wait_ticks(3);
      idle();
      check_eq("blink_toggle", 32'(blink), 32'd0);

      // Single adjust, then auto-repeat while held.
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check_eq("adj_single", 32'(adj_pulse), 32'd1);
      idle();
      check_eq("adj_single_end", 32'(adj_pulse), 32'd0);
      hold_lvl = 1'b1;
      n_adj = 0;
      wait_ticks(15);
      idle();
      check_eq("adj_repeat_count", n_adj, 32'd6);
      hold_lvl = 1'b0;
      n_adj = 0;
      wait_ticks(10);
      check_eq("adj_released", n_adj, 32'd0);

      // Clear in the middle of RUN.
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      wait_hund(77);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_eq("cr_outs", 32'({tick_100hz, scan_en, sec_en, adj_pulse, blink, hund, mode}), 32'd0);
      repeat (3) idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
